fetch_pcgen: RTL



---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_pcgen_if.sv | 23 ++
 rtl/fetch_slot_sel.sv | 35 +++
 rtl/fetch_pcgen.sv | 100 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch PC generator: address width, reset PC, FSM states
// and the fetch bundle handed to the instruction-fetch queue.
`ifndef AMSB
`define AMSB 51
`endif

package fetch_pkg;
  localparam int AMSB = `AMSB;

  typedef logic [AMSB:0] addr_t;

  localparam logic [51:0] RSTIP  = 52'hFFFFFFFFE0000;
  localparam addr_t       RST_PC = addr_t'(RSTIP);
  localparam addr_t       ILEN   = addr_t'(1);

  typedef enum logic {
    ST_LOOK = 1'b0,
    ST_DEC  = 1'b1
  } state_t;

  typedef struct packed {
    addr_t      pc;
    logic [1:0] cnt;
    logic       taken;
    addr_t      npc;
  } fetch_bundle_t;
endpackage

// File: rtl/fetch_pcgen_if.sv
// Fetch bundle channel from the PC generator (master) to the fetch queue (slave).
// Handshake: a bundle transfers on a clock edge where fetch_v and fetch_rdy are both 1;
// fetch_v never depends on fetch_rdy, and the bundle fields are meaningful only while fetch_v=1.
interface fetch_pcgen_if
  import fetch_pkg::*;
();
  logic       fetch_v;
  logic       fetch_rdy;
  addr_t      fetch_pc;
  logic [1:0] fetch_cnt;
  logic       fetch_taken;
  addr_t      fetch_npc;

  modport master (
    output fetch_v, fetch_pc, fetch_cnt, fetch_taken, fetch_npc,
    input  fetch_rdy
  );

  modport slave (
    input  fetch_v, fetch_pc, fetch_cnt, fetch_taken, fetch_npc,
    output fetch_rdy
  );
endinterface

// File: rtl/fetch_slot_sel.sv
// Priority encoder over three instruction slots: the first BTB hit ends the bundle,
// otherwise all three slots are fetched and the PC falls through.
module fetch_slot_sel
  import fetch_pkg::*;
(
  input  logic       hit_a,
  input  logic       hit_b,
  input  logic       hit_c,
  input  addr_t      tgt_a,
  input  addr_t      tgt_b,
  input  addr_t      tgt_c,
  input  addr_t      fall,
  output logic [1:0] cnt,
  output logic       taken,
  output addr_t      npc
);
  always_comb begin
    cnt   = 2'd3;
    taken = 1'b0;
    npc   = fall;
    if (hit_a) begin
      cnt   = 2'd1;
      taken = 1'b1;
      npc   = tgt_a;
    end else if (hit_b) begin
      cnt   = 2'd2;
      taken = 1'b1;
      npc   = tgt_b;
    end else if (hit_c) begin
      cnt   = 2'd3;
      taken = 1'b1;
      npc   = tgt_c;
    end
  end
endmodule

// File: rtl/fetch_pcgen.sv
// Fetch PC generator: holds three sequential lookup addresses across the two-cycle
// BTB lookup, then offers a fetch bundle and advances to the predicted next PC.
module fetch_pcgen
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   redirect,
  input  addr_t  redirect_pc,
  output addr_t  pcA,
  output addr_t  pcB,
  output addr_t  pcC,
  output addr_t  npcA,
  output addr_t  npcB,
  output addr_t  npcC,
  input  logic   hitA,
  input  logic   hitB,
  input  logic   hitC,
  input  addr_t  btgtA,
  input  addr_t  btgtB,
  input  addr_t  btgtC,
  fetch_pcgen_if.master fq,
  output state_t dbg_state
);
  localparam addr_t ILEN2 = ILEN + ILEN;
  localparam addr_t ILEN3 = ILEN2 + ILEN;

  state_t        state, state_n;
  addr_t         pc, pc_n;
  addr_t         inc1, inc2, inc3;
  fetch_bundle_t bundle;
  logic          bundle_v;

  // All three increments come from the same pc so the adders run in parallel.
  assign inc1 = pc + ILEN;
  assign inc2 = pc + ILEN2;
  assign inc3 = pc + ILEN3;

  assign pcA  = pc;
  assign pcB  = inc1;
  assign pcC  = inc2;
  assign npcA = inc1;
  assign npcB = inc2;
  assign npcC = inc3;

  fetch_slot_sel u_slot_sel (
    .hit_a (hitA),
    .hit_b (hitB),
    .hit_c (hitC),
    .tgt_a (btgtA),
    .tgt_b (btgtB),
    .tgt_c (btgtC),
    .fall  (inc3),
    .cnt   (bundle.cnt),
    .taken (bundle.taken),
    .npc   (bundle.npc)
  );

  assign bundle.pc = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOOK;
      pc    <= RST_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  // A redirect masks the bundle in its own cycle so a coincident fetch_rdy cannot accept it.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    bundle_v = 1'b0;
    if (redirect) begin
      state_n = ST_LOOK;
      pc_n    = redirect_pc;
    end else begin
      case (state)
        ST_LOOK: state_n = ST_DEC;
        ST_DEC: begin
          bundle_v = 1'b1;
          if (fq.fetch_rdy) begin
            state_n = ST_LOOK;
            pc_n    = bundle.npc;
          end
        end
        default: state_n = ST_LOOK;
      endcase
    end
  end

  assign fq.fetch_v     = bundle_v;
  assign fq.fetch_pc    = bundle.pc;
  assign fq.fetch_cnt   = bundle.cnt;
  assign fq.fetch_taken = bundle.taken;
  assign fq.fetch_npc   = bundle.npc;
  assign dbg_state      = state;
endmodule
